// File: rtl/muldiv_issue_arbiter.sv
// Round-robin issue arbiter for a shared MUL/DIV unit. Tracks in-flight
// multiplies in a valid/tag shift register and a single divide via a small
// FSM, and drives one backpressured writeback slot toward the CDB.
module muldiv_issue_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TAG_WIDTH   = 6,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 33
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_is_div,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]             grant,
  input  logic                           clear_en,
  output logic                           fu_start,
  output logic                           fu_is_div,
  output logic                           fu_stall,
  output logic                           fu_kill,
  output logic                           wb_valid,
  output logic [TAG_WIDTH-1:0]           wb_tag,
  input  logic                           wb_ready
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_BUSY,
    S_DIV_WB
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [MUL_LATENCY-1:0] mul_vld_q, mul_vld_d;
  logic [TAG_WIDTH-1:0]   mul_tag_q [MUL_LATENCY];
  logic [TAG_WIDTH-1:0]   mul_tag_d [MUL_LATENCY];
  logic [TAG_WIDTH-1:0]   div_tag_q, div_tag_d;

  logic [TAG_WIDTH-1:0]   req_tag_arr [NUM_REQ];
  logic                   mul_stall;
  logic                   arb_en;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_div;
  logic [TAG_WIDTH-1:0]   gnt_tag;
  logic                   mul_wb;
  logic                   div_wb;

  // Unpack the flat per-queue tag bus.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_tag_arr[i] = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  assign mul_wb    = mul_vld_q[MUL_LATENCY-1];
  assign div_wb    = (state_q == S_DIV_WB);
  assign mul_stall = mul_wb & ~wb_ready;
  assign arb_en    = rst & (state_q == S_IDLE) & ~clear_en & ~mul_stall;

  // Round-robin search starting at rr_ptr; a DIV is only eligible with an empty mul pipe.
  always_comb begin
    int unsigned      pos;
    logic [PTR_W-1:0] cand;
    logic             found;
    grant   = '0;
    gnt_idx = '0;
    gnt_div = 1'b0;
    gnt_tag = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = pos[PTR_W-1:0];
      if (!found && arb_en && req_valid[cand] &&
          (!req_is_div[cand] || (mul_vld_q == '0))) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
        gnt_div     = req_is_div[cand];
        gnt_tag     = req_tag_arr[cand];
      end
    end
  end

  assign fu_start  = |grant;
  assign fu_is_div = fu_start & gnt_div;
  assign fu_stall  = mul_stall;
  assign fu_kill   = clear_en & rst;
  assign wb_valid  = ~clear_en & (mul_wb | div_wb);
  assign wb_tag    = !wb_valid ? '0 : (mul_wb ? mul_tag_q[MUL_LATENCY-1] : div_tag_q);

  // Next-state: flush wins; otherwise advance mul pipe (unless stalled), divide FSM and rr pointer.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    mul_vld_d = mul_vld_q;
    mul_tag_d = mul_tag_q;
    div_tag_d = div_tag_q;
    if (clear_en) begin
      mul_vld_d = '0;
      state_d   = S_IDLE;
      div_cnt_d = '0;
    end else begin
      if (!mul_stall) begin
        for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
          mul_vld_d[i] = mul_vld_q[i-1];
          mul_tag_d[i] = mul_tag_q[i-1];
        end
        mul_vld_d[0] = fu_start & ~gnt_div;
        mul_tag_d[0] = gnt_tag;
      end
      unique case (state_q)
        S_IDLE: begin
          if (fu_start && gnt_div) begin
            state_d   = S_DIV_BUSY;
            div_cnt_d = CNT_W'(DIV_LATENCY - 1);
            div_tag_d = gnt_tag;
          end
        end
        S_DIV_BUSY: begin
          if (div_cnt_q == CNT_W'(1)) begin
            state_d   = S_DIV_WB;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q - 1'b1;
          end
        end
        S_DIV_WB: begin
          if (wb_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (fu_start) begin
        rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      rr_ptr_q  <= '0;
      mul_vld_q <= '0;
      mul_tag_q <= '{default: '0};
      div_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      mul_vld_q <= mul_vld_d;
      mul_tag_q <= mul_tag_d;
      div_tag_q <= div_tag_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Bench for muldiv_issue_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_muldiv_issue_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int ML = 3;
  localparam int DL = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_is_div;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    grant;
  logic            clear_en, fu_start, fu_is_div, fu_stall, fu_kill;
  logic            wb_valid, wb_ready;
  logic [TW-1:0]   wb_tag;

  muldiv_issue_arbiter #(
    .NUM_REQ    (N),
    .TAG_WIDTH  (TW),
    .MUL_LATENCY(ML),
    .DIV_LATENCY(DL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_is_div(req_is_div),
    .req_tag   (req_tag),
    .grant     (grant),
    .clear_en  (clear_en),
    .fu_start  (fu_start),
    .fu_is_div (fu_is_div),
    .fu_stall  (fu_stall),
    .fu_kill   (fu_kill),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_ready  (wb_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: multiplies as a list of (cycles-to-writeback, tag),
  // divide as an active flag plus the absolute cycle its result is due.
  typedef struct {
    int            cnt;
    logic [TW-1:0] tag;
  } mop_t;
  mop_t          mq[$];
  int            rr;
  bit            div_act;
  int            div_done;
  logic [TW-1:0] div_tag;

  // Sampled DUT outputs of the latest step.
  logic [N-1:0]  s_grant;
  logic          s_start, s_isdiv, s_stall, s_kill, s_wbv;
  logic [TW-1:0] s_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [TW-1:0] tag_of(input int i);
    return req_tag[i*TW +: TW];
  endfunction

  function automatic void model_reset();
    mq.delete();
    rr      = 0;
    div_act = 0;
    div_done = 0;
    div_tag = '0;
  endfunction

  // One clock cycle: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    bit           mwbmul, mdivwb, mstall, mwbv;
    logic [TW-1:0] mtag;
    logic [N-1:0] mg;
    int           gi;
    @(negedge clk);
    mwbmul = (mq.size() > 0) && (mq[0].cnt == 0);
    mdivwb = div_act && (cyc >= div_done);
    mstall = mwbmul && !wb_ready;
    mwbv   = !clear_en && (mwbmul || mdivwb);
    mtag   = mwbmul ? mq[0].tag : div_tag;
    mg     = '0;
    gi     = -1;
    if (rst && !clear_en && !mstall && !div_act) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (gi < 0 && req_valid[i] && (!req_is_div[i] || mq.size() == 0)) begin
          gi    = i;
          mg[i] = 1'b1;
        end
      end
    end
    s_grant = grant; s_start = fu_start; s_isdiv = fu_is_div; s_stall = fu_stall;
    s_kill  = fu_kill; s_wbv = wb_valid; s_tag = wb_tag;
    if (!rst) begin
      chk("rst_grant", 32'(grant), 0);
      chk("rst_start", 32'(fu_start), 0);
      chk("rst_isdiv", 32'(fu_is_div), 0);
      chk("rst_stall", 32'(fu_stall), 0);
      chk("rst_kill", 32'(fu_kill), 0);
      chk("rst_wbv", 32'(wb_valid), 0);
      chk("rst_tag", 32'(wb_tag), 0);
    end else begin
      chk("grant", 32'(grant), 32'(mg));
      chk("fu_start", 32'(fu_start), 32'(gi >= 0));
      chk("fu_is_div", 32'(fu_is_div), 32'((gi >= 0) && req_is_div[gi]));
      chk("fu_kill", 32'(fu_kill), 32'(clear_en));
      if (!clear_en) chk("fu_stall", 32'(fu_stall), 32'(mstall));
      chk("wb_valid", 32'(wb_valid), 32'(mwbv));
      if (mwbv) chk("wb_tag", 32'(wb_tag), 32'(mtag));
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (clear_en) begin
      mq.delete();
      div_act = 0;
    end else begin
      if (!mstall) begin
        if (mwbmul) void'(mq.pop_front());
        foreach (mq[j]) mq[j].cnt--;
      end
      if (mdivwb && wb_ready) div_act = 0;
      if (gi >= 0) begin
        if (req_is_div[gi]) begin
          div_act  = 1;
          div_done = cyc + DL;
          div_tag  = tag_of(gi);
        end else begin
          mq.push_back('{cnt: ML - 1, tag: tag_of(gi)});
        end
        rr = (gi + 1) % N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_tag(input int q, input int t);
    req_tag[q*TW +: TW] = TW'(t);
  endtask

  initial begin
    bit found;
    rst = 1'b0; req_valid = '0; req_is_div = '0; req_tag = '0;
    clear_en = 1'b0; wb_ready = 1'b1;
    model_reset();
    repeat (2) step();
    rst = 1'b1;

    // 1: four MUL requesters, rotating grants, each written back 3 cycles later.
    req_valid = 4'b1111; req_is_div = '0;
    for (int i = 0; i < N; i++) set_tag(i, 10 + i);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_grant", 32'(s_grant), 32'(1) << k);
      if (k == 3) chk("t1_wb_first", 32'(s_wbv ? s_tag : 6'h3f), 10);
    end
    req_valid = '0;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t1_wb_tag", 32'(s_wbv ? s_tag : 6'h3f), 32'(10 + k));
    end
    repeat (2) step();

    // 2: queue 2 DIV tag 5; silence for DL-1 cycles, result at exactly DL.
    req_valid = 4'b0100; req_is_div = 4'b0100; set_tag(2, 5);
    step();
    chk("t2_grant", 32'(s_grant), 32'h4);
    chk("t2_isdiv", 32'(s_isdiv), 1);
    req_valid = 4'b1111; req_is_div = '0;
    for (int k = 1; k <= DL; k++) begin
      step();
      chk("t2_nogrant", 32'(s_grant), 0);
      chk("t2_wbv", 32'(s_wbv), 32'(k == DL));
      if (k == DL) chk("t2_wbtag", 32'(s_tag), 5);
    end
    step();
    chk("t2_after", 32'(s_grant), 32'h8);
    req_valid = '0;
    repeat (5) step();

    // 4: writeback backpressure for 5 cycles on a MUL at the wb stage.
    req_valid = 4'b0001; set_tag(0, 7);
    step();
    chk("t4_grant", 32'(s_grant), 32'h1);
    req_valid = '0;
    repeat (2) step();
    wb_ready = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_stall", 32'(s_stall), 1);
      chk("t4_grant0", 32'(s_grant), 0);
      chk("t4_tag", 32'(s_wbv ? s_tag : 6'h3f), 7);
    end
    wb_ready = 1'b1; req_valid = '0;
    step();
    chk("t4_retire", 32'(s_wbv ? s_tag : 6'h3f), 7);
    step();
    chk("t4_empty", 32'(s_wbv), 0);
    repeat (2) step();

    // 3: DIV waits for the mul pipe to empty while other MULs keep flowing.
    req_valid = 4'b0010; req_is_div = '0; set_tag(1, 20);
    step();
    chk("t3_mul", 32'(s_grant), 32'h2);
    req_valid = 4'b0011; req_is_div = 4'b0001; set_tag(0, 21);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_mul_only", 32'(s_grant), 32'h2);
    end
    req_valid = 4'b0001;
    for (int k = 1; k <= ML; k++) begin
      step();
      chk("t3_div_wait", 32'(s_grant), 0);
    end
    step();
    chk("t3_div_grant", 32'(s_grant), 32'h1);
    chk("t3_div_isdiv", 32'(s_isdiv), 1);
    req_valid = '0; req_is_div = '0;
    repeat (DL + 2) step();

    // 5: flush 7 cycles into a divide; rr pointer survives the flush.
    req_valid = 4'b1000; req_is_div = 4'b1000; set_tag(3, 9);
    step();
    chk("t5_grant", 32'(s_grant), 32'h8);
    req_valid = '0; req_is_div = '0;
    repeat (7) step();
    clear_en = 1'b1; req_valid = 4'b1111;
    step();
    chk("t5_kill", 32'(s_kill), 1);
    chk("t5_grant0", 32'(s_grant), 0);
    clear_en = 1'b0;
    step();
    chk("t5_rr_kept", 32'(s_grant), 32'h1);
    req_valid = '0;
    for (int k = 0; k < DL + 5; k++) begin
      step();
      if (s_wbv) chk("t5_no_div_wb", 32'(s_tag == 6'd9), 0);
    end

    // 6: async reset while a divide result is held in the slot.
    req_valid = 4'b0010; req_is_div = 4'b0010; set_tag(1, 17);
    step();
    chk("t6_grant", 32'(s_grant), 32'h2);
    req_valid = '0; req_is_div = '0; wb_ready = 1'b0;
    found = 0;
    for (int k = 0; k < DL + 5 && !found; k++) begin
      step();
      if (s_wbv) found = 1;
    end
    chk("t6_wb_seen", 32'(found), 1);
    chk("t6_wb_tag", 32'(s_tag), 17);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_out", {grant, fu_start, fu_is_div, fu_stall, fu_kill, wb_valid, wb_tag}, 0);
    model_reset();
    step();
    rst = 1'b1; wb_ready = 1'b1; req_valid = 4'b1111; req_is_div = '0;
    step();
    chk("t6_first_grant", 32'(s_grant), 32'h1);
    req_valid = '0;
    repeat (4) step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_is_div[i] = ($urandom_range(0, 5) == 0);
      req_tag  = (N*TW)'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      clear_en = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
